// File: rtl/led_matrix_pkg.sv
// Shared constants and helpers for the row-multiplexed LED matrix scanner.
// Pin polarities live here so the panel wiring is described in one place.
package led_matrix_pkg;

  localparam logic ROW_ACTIVE = 1'b1;
  localparam logic COL_ACTIVE = 1'b0;

  localparam int DEF_ROWS         = 5;
  localparam int DEF_COLS         = 7;
  localparam int DEF_PRESCALE     = 50000;
  localparam int DEF_BLANK_CYCLES = 2;

  localparam int MAX_ROWS = 32;

  function automatic logic [MAX_ROWS-1:0] onehot_row(input int unsigned idx);
    return MAX_ROWS'(1) << idx;
  endfunction

endpackage

// File: rtl/scan_timebase.sv
// Row-slot prescaler and row counter; both are held at zero while scanning is disabled.
// slot_end / frame_end flag the last cycle of a row slot / of the whole frame.
module scan_timebase #(
  parameter int ROWS     = 5,
  parameter int PRESCALE = 50000
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic                                          enable,
  output logic [((PRESCALE > 1) ? $clog2(PRESCALE) : 1)-1:0] cnt,
  output logic [$clog2(ROWS)-1:0]                       row_idx,
  output logic                                          slot_end,
  output logic                                          frame_end
);

  localparam int CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RIDX_W = $clog2(ROWS);

  assign slot_end  = enable && (cnt == CNT_W'(PRESCALE - 1));
  assign frame_end = slot_end && (row_idx == RIDX_W'(ROWS - 1));

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST || !enable) begin
      cnt     <= '0;
      row_idx <= '0;
    end else if (slot_end) begin
      cnt     <= '0;
      row_idx <= (row_idx == RIDX_W'(ROWS - 1)) ? '0 : row_idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix driver with double-buffered frame, per-slot blanking
// and run-time brightness; all pin outputs are registered.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter  int ROWS         = DEF_ROWS,
  parameter  int COLS         = DEF_COLS,
  parameter  int PRESCALE     = DEF_PRESCALE,
  parameter  int BLANK_CYCLES = DEF_BLANK_CYCLES,
  localparam int DUTY_W       = $clog2(PRESCALE + 1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     enable,
  input  logic [ROWS*COLS-1:0]     frame_in,
  input  logic                     load,
  input  logic [DUTY_W-1:0]        duty,
  output logic [ROWS-1:0]          row_o,
  output logic [COLS-1:0]          col_o,
  output logic [$clog2(ROWS)-1:0]  row_idx,
  output logic                     frame_start,
  output logic                     pending
);

  localparam int CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int ON_MAX = PRESCALE - BLANK_CYCLES;

  logic [CNT_W-1:0]     cnt;
  logic                 slot_end;
  logic                 frame_end;
  logic                 boundary;
  logic [ROWS*COLS-1:0] shadow;
  logic [ROWS*COLS-1:0] active;
  int                   on_cycles;
  logic                 in_window;

  scan_timebase #(
    .ROWS     (ROWS),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .CLK       (CLK),
    .RST       (RST),
    .enable    (enable),
    .cnt       (cnt),
    .row_idx   (row_idx),
    .slot_end  (slot_end),
    .frame_end (frame_end)
  );

  assign boundary = slot_end && frame_end;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    on_cycles = (int'(duty) > ON_MAX) ? ON_MAX : int'(duty);
    in_window = enable && (int'(cnt) >= BLANK_CYCLES)
                       && (int'(cnt) < BLANK_CYCLES + on_cycles);
  end

  // NOTE: the frame buffers are plain registers, so they are reset with the
  // rest of the state and a fresh panel never shows stale content.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (load && (!enable || boundary)) begin
      // New data wins on a boundary; with scanning stopped there is nothing to tear.
      shadow  <= frame_in;
      active  <= frame_in;
      pending <= 1'b0;
    end else if (load) begin
      shadow  <= frame_in;
      pending <= 1'b1;
    end else if (boundary && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      row_o       <= {ROWS{~ROW_ACTIVE}};
      col_o       <= {COLS{~COL_ACTIVE}};
      frame_start <= 1'b0;
    end else begin
      if (in_window) begin
        row_o <= ROWS'(onehot_row(32'(row_idx))) ^ {ROWS{~ROW_ACTIVE}};
        col_o <= active[32'(row_idx)*COLS +: COLS] ^ {COLS{~COL_ACTIVE}};
      end else begin
        row_o <= {ROWS{~ROW_ACTIVE}};
        col_o <= {COLS{~COL_ACTIVE}};
      end
      frame_start <= enable && (cnt == '0) && (row_idx == '0);
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench: directed scenarios plus random traffic against a frame-level
// model that tracks elapsed enabled cycles and derives slot/row by division.
module tb_led_matrix_scanner;

  localparam int ROWS     = 5;
  localparam int COLS     = 7;
  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;
  localparam int FRAME    = ROWS * PRESCALE;
  localparam int NB       = ROWS * COLS;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic [NB-1:0] frame_in = '0;
  logic [3:0]    duty = '0;
  logic [4:0]    row_o;
  logic [6:0]    col_o;
  logic [2:0]    row_idx;
  logic          frame_start;
  logic          pending;

  int n_cmp = 0;
  int n_err = 0;
  int lit_cnt = 0;
  int fs_cnt = 0;

  // Reference state: cycles since scanning (re)started, and the two frame images.
  int            m_t = 0;
  logic [NB-1:0] m_shadow = '0;
  logic [NB-1:0] m_active = '0;
  logic          m_pending = 1'b0;

  always #5 CLK = ~CLK;

  led_matrix_scanner #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .enable      (enable),
    .frame_in    (frame_in),
    .load        (load),
    .duty        (duty),
    .row_o       (row_o),
    .col_o       (col_o),
    .row_idx     (row_idx),
    .frame_start (frame_start),
    .pending     (pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from pre-edge inputs, advance the model, compare after the edge.
  task automatic step();
    logic [31:0] e_row, e_col, e_fs, e_idx;
    int          pos, row, on;
    logic        bnd;
    e_row = 32'h0;
    e_col = 32'h7F;
    e_fs  = 32'h0;
    e_idx = 32'h0;
    if (RST) begin
      m_t = 0; m_shadow = '0; m_active = '0; m_pending = 1'b0;
    end else if (!enable) begin
      m_t = 0;
      if (load) begin
        m_shadow = frame_in; m_active = frame_in; m_pending = 1'b0;
      end
    end else begin
      pos = m_t % PRESCALE;
      row = (m_t / PRESCALE) % ROWS;
      on  = (int'(duty) > PRESCALE - BLANK) ? PRESCALE - BLANK : int'(duty);
      if (pos >= BLANK && pos < BLANK + on) begin
        e_row = 32'h1 << row;
        for (int c = 0; c < COLS; c++) e_col[c] = ~m_active[row*COLS + c];
      end
      e_fs = {31'h0, (m_t % FRAME) == 0};
      bnd  = (m_t % FRAME) == FRAME - 1;
      if (load) begin
        m_shadow = frame_in;
        if (bnd) begin
          m_active = frame_in; m_pending = 1'b0;
        end else begin
          m_pending = 1'b1;
        end
      end else if (bnd && m_pending) begin
        m_active = m_shadow; m_pending = 1'b0;
      end
      m_t++;
      e_idx = 32'((m_t / PRESCALE) % ROWS);
    end
    @(posedge CLK);
    #1;
    check("row_o", 32'(row_o), e_row);
    check("col_o", 32'(col_o), e_col);
    check("frame_start", 32'(frame_start), e_fs);
    check("row_idx", 32'(row_idx), e_idx);
    check("pending", 32'(m_pending), 32'(pending));
    lit_cnt += (row_o != '0) ? 1 : 0;
    fs_cnt  += frame_start ? 1 : 0;
  endtask

  // Stop scanning, load a frame directly, restart from row 0 with the given duty.
  task automatic restart(input logic [NB-1:0] img, input logic [3:0] d);
    enable = 1'b0; load = 1'b1; frame_in = img; duty = d;
    step();
    load = 1'b0; enable = 1'b1;
    lit_cnt = 0; fs_cnt = 0;
  endtask

  initial begin
    logic [NB-1:0] img;

    RST = 1'b1;
    repeat (2) step();
    RST = 1'b0;

    // Single LED at (0,0), duty 6: dark two cycles, then lit for six.
    restart(NB'(1), 4'd6);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t2_row", 32'(row_o), (k >= 3) ? 32'h01 : 32'h00);
      check("t2_col", 32'(col_o), (k >= 3) ? 32'h7E : 32'h7F);
    end
    repeat (32) step();

    // Brightness over one full frame.
    restart('1, 4'd3);
    repeat (FRAME) step();
    check("t3_lit_duty3", 32'(lit_cnt), 32'(ROWS * 3));
    check("t4_fs_per_frame", 32'(fs_cnt), 32'd1);
    restart('1, 4'd0);
    repeat (FRAME) step();
    check("t3_lit_duty0", 32'(lit_cnt), 32'd0);
    restart('1, 4'd15);
    repeat (FRAME) step();
    check("t3_lit_duty15", 32'(lit_cnt), 32'(ROWS * 6));

    // Scan order, wrapping back to row 0.
    restart('1, 4'd6);
    repeat (2) step();
    for (int i = 0; i < 6; i++) begin
      step();
      check("t4_scan", 32'(row_o), 32'h1 << (i % ROWS));
      repeat (PRESCALE - 1) step();
    end

    // Tear-free swap: load at row 2, old image until the frame boundary.
    img = NB'({$urandom(), $urandom()});
    restart(img, 4'd6);
    repeat (17) step();
    frame_in = ~img; load = 1'b1;
    step();
    load = 1'b0;
    check("t5_pending_set", 32'(pending), 32'd1);
    repeat (22) step();
    check("t5_pending_clr", 32'(pending), 32'd0);

    // Load exactly on the boundary cycle.
    repeat (FRAME - 1) step();
    frame_in = NB'({$urandom(), $urandom()}); load = 1'b1;
    step();
    load = 1'b0;
    check("t6_bnd_pending", 32'(pending), 32'd0);
    repeat (FRAME) step();

    // Two loads before a boundary: the second one is displayed.
    repeat (5) step();
    frame_in = NB'({$urandom(), $urandom()}); load = 1'b1;
    step();
    frame_in = NB'({$urandom(), $urandom()});
    step();
    load = 1'b0;
    check("t6_two_loads_pending", 32'(pending), 32'd1);
    repeat (2 * FRAME) step();

    // Enable dropped mid-slot.
    repeat (11) step();
    enable = 1'b0;
    step();
    check("t6_drop_row", 32'(row_o), 32'h0);
    check("t6_drop_idx", 32'(row_idx), 32'h0);
    enable = 1'b1;
    repeat (20) step();

    // Reset mid-scan with a pending frame.
    frame_in = NB'({$urandom(), $urandom()}); load = 1'b1;
    step();
    load = 1'b0; RST = 1'b1;
    step();
    RST = 1'b0;
    check("t1_rst_row", 32'(row_o), 32'h00);
    check("t1_rst_col", 32'(col_o), 32'h7F);
    check("t1_rst_pending", 32'(pending), 32'd0);
    check("t1_rst_idx", 32'(row_idx), 32'd0);

    // Random traffic.
    enable = 1'b1; duty = 4'd5;
    for (int n = 0; n < 1500; n++) begin
      load = ($urandom_range(0, 19) == 0);
      if (load) frame_in = NB'({$urandom(), $urandom()});
      if ($urandom_range(0, 99) == 0) duty = 4'($urandom_range(0, 15));
      if (enable ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 4) == 0))
        enable = ~enable;
      RST = ($urandom_range(0, 799) == 0);
      step();
    end
    load = 1'b0; RST = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
